mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 134 +++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the CPU memory access unit: size codes, FSM states,
// the default timeout and the access legality rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SizeByte  = 2'd0,
    SizeHalf  = 2'd1,
    SizeWord  = 2'd2,
    SizeDword = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam int unsigned DefaultTimeout = 16;

  // Misaligned for its size, or a dword access on a 32-bit datapath.
  function automatic logic is_illegal(input logic [2:0] addr_lsb, input size_e size,
                                      input int unsigned dw);
    logic [2:0] align_mask;
    align_mask = (3'd1 << size) - 3'd1;
    return ((addr_lsb & align_mask) != 3'd0) || ((size == SizeDword) && (dw == 32));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side operation/response and memory-side request/ack bundle.
interface mem_access_unit_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 12
);
  localparam int unsigned OW = $clog2(DW / 8);

  logic              op_valid;
  logic              op_ready;
  logic              op_wr;
  logic [1:0]        op_size;
  logic              op_signed;
  logic [AW-1:0]     op_addr;
  logic [DW-1:0]     op_wdata;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [AW-OW-1:0]  mem_addr;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_rdata;

  // Driver side: the CPU and the memory together.
  modport master (
    output op_valid, op_wr, op_size, op_signed, op_addr, op_wdata, mem_ack, mem_rdata,
    input  op_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );

  // The access unit itself.
  modport slave (
    input  op_valid, op_wr, op_size, op_signed, op_addr, op_wdata, mem_ack, mem_rdata,
    output op_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be,
           mem_wdata
  );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed lanes of a read word, right-aligns them and
// sign- or zero-extends to the full data width.
module load_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]             rdata,
  input  size_e                     size,
  input  logic                      sign,
  input  logic [$clog2(DW/8)-1:0]   offset,
  output logic [DW-1:0]             data
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned IW = $clog2(DW);

  logic [DW-1:0] shifted;
  int unsigned   nbytes;
  logic [IW-1:0] msb_idx;
  logic          fill;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    nbytes  = 32'd1 << size;
    // A dword on a 32-bit datapath never reaches here; clamp to keep indices in range.
    if (nbytes > NB) nbytes = NB;
    msb_idx = IW'(nbytes * 8 - 1);
    fill    = sign & shifted[msb_idx];
    data    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      data[i*8 +: 8] = (i < nbytes) ? shifted[i*8 +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: registers a CPU access, issues one memory
// request with lane enables/replication, and returns an extended, one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned IW = $clog2(DW);

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  size_e         size_q, size_d;
  logic          sign_q, sign_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          in_access;
  logic [DW-1:0] aligned_rdata;

  load_align #(
    .DW (DW)
  ) u_load_align (
    .rdata  (bus.mem_rdata),
    .size   (size_q),
    .sign   (sign_q),
    .offset (addr_q[OW-1:0]),
    .data   (aligned_rdata)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.op_valid) begin
          wr_d    = bus.op_wr;
          size_d  = size_e'(bus.op_size);
          sign_d  = bus.op_signed;
          addr_d  = bus.op_addr;
          wdata_d = bus.op_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = is_illegal(bus.op_addr[2:0], size_e'(bus.op_size), DW);
          state_d = err_d ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (bus.mem_ack) begin
          rdata_d = wr_q ? '0 : aligned_rdata;
          state_d = StResp;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      size_q  <= SizeByte;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_access     = (state_q == StAccess);
  assign bus.op_ready  = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_err   = bus.rsp_valid & err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_req   = in_access;
  assign bus.mem_we    = in_access & wr_q;
  assign bus.mem_addr  = in_access ? addr_q[AW-1:OW] : '0;

  int unsigned   nbytes;
  logic [NB-1:0] lane_mask;
  logic [IW-1:0] src_idx;

  // Memory-side lane enables and replicated store data, forced to zero outside ACCESS.
  always_comb begin
    nbytes        = 32'd1 << size_q;
    lane_mask     = NB'((16'd1 << nbytes) - 16'd1);
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    src_idx       = '0;
    if (in_access) begin
      bus.mem_be = lane_mask << addr_q[OW-1:0];
      for (int unsigned i = 0; i < NB; i++) begin
        src_idx = IW'((i % nbytes) * 8);
        bus.mem_wdata[i*8 +: 8] = wdata_q[src_idx +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;
  localparam int unsigned TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_access_unit_if #(.DW(32), .AW(12)) bus ();
  mem_access_unit_if #(.DW(64), .AW(12)) bus64 ();

  mem_access_unit #(.DW(32), .AW(12), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_access_unit #(.DW(64), .AW(12), .TIMEOUT(TIMEOUT)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model, 32-bit datapath
  function automatic bit ref_illegal(input logic [1:0] size, input logic [11:0] addr);
    int unsigned n;
    n = 1 << size;
    return ((addr % n) != 0) || (size == 2'd3);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [11:0] addr);
    int unsigned n, off;
    n   = 1 << size;
    off = addr % 4;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    int unsigned n;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wdata[(i % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn,
                                           input logic [11:0] addr, input logic [31:0] rdata);
    longint unsigned n, off, mask, v;
    n    = 1 << size;
    off  = addr % 4;
    mask = (64'd1 << (8 * n)) - 1;
    v    = (64'(rdata) >> (8 * off)) & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic run_op(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [11:0] addr, input logic [31:0] wdata,
                        input int ack_delay, input logic [31:0] rdata);
    bit ill, got_rsp, timed_out;
    int req_cycles, exp_cycles;
    ill       = ref_illegal(size, addr);
    timed_out = (ack_delay >= int'(TIMEOUT));
    @(negedge clk);
    check_eq("op_ready_idle", bus.op_ready, 1);
    bus.op_valid  = 1'b1;
    bus.op_wr     = wr;
    bus.op_size   = size;
    bus.op_signed = sgn;
    bus.op_addr   = addr;
    bus.op_wdata  = wdata;
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (ill) begin
      check_eq("ill_mem_req", bus.mem_req, 0);
      check_eq("ill_rsp_valid", bus.rsp_valid, 1);
      check_eq("ill_rsp_err", bus.rsp_err, 1);
      check_eq("ill_rsp_rdata", bus.rsp_rdata, 0);
    end else begin
      exp_cycles = timed_out ? int'(TIMEOUT) : ack_delay + 1;
      req_cycles = 0;
      got_rsp    = 1'b0;
      for (int c = 0; c < int'(TIMEOUT) + 4 && !got_rsp; c++) begin
        if (c > 0) @(negedge clk);
        bus.mem_ack = 1'b0;
        if (bus.rsp_valid) begin
          got_rsp = 1'b1;
        end else if (bus.mem_req) begin
          req_cycles++;
          check_eq("mem_we", bus.mem_we, wr);
          check_eq("mem_addr", bus.mem_addr, addr[11:2]);
          check_eq("mem_be", bus.mem_be, ref_be(size, addr));
          check_eq("mem_wdata", bus.mem_wdata, ref_wdata(size, wdata));
          if (req_cycles - 1 == ack_delay) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
          end
        end
      end
      check_eq("rsp_seen", got_rsp, 1);
      check_eq("req_cycles", req_cycles, exp_cycles);
      check_eq("rsp_err", bus.rsp_err, timed_out);
      check_eq("rsp_rdata", bus.rsp_rdata,
               (timed_out || wr) ? 32'd0 : ref_load(size, sgn, addr, rdata));
    end
    check_eq("op_ready_in_rsp", bus.op_ready, 0);
    // Stray acks in RESP and IDLE must be ignored
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    @(negedge clk);
    check_eq("rsp_single_cycle", bus.rsp_valid, 0);
    check_eq("op_ready_after", bus.op_ready, 1);
    check_eq("no_req_after", bus.mem_req, 0);
    bus.mem_ack = 1'b0;
  endtask

  task automatic run64(input logic [1:0] size, input logic sgn, input logic [11:0] addr,
                       input logic [63:0] rdata, input logic [7:0] exp_be,
                       input logic [63:0] exp_rdata);
    @(negedge clk);
    bus64.op_valid  = 1'b1;
    bus64.op_wr     = 1'b0;
    bus64.op_size   = size;
    bus64.op_signed = sgn;
    bus64.op_addr   = addr;
    @(negedge clk);
    bus64.op_valid = 1'b0;
    check_eq("d64_mem_req", bus64.mem_req, 1);
    check_eq("d64_mem_be", bus64.mem_be, exp_be);
    check_eq("d64_mem_addr", bus64.mem_addr, addr[11:3]);
    bus64.mem_ack   = 1'b1;
    bus64.mem_rdata = rdata;
    @(negedge clk);
    bus64.mem_ack = 1'b0;
    check_eq("d64_rsp_valid", bus64.rsp_valid, 1);
    check_eq("d64_rsp_err", bus64.rsp_err, 0);
    check_eq("d64_rsp_rdata", bus64.rsp_rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  size;
    logic [11:0] addr;
    int          r, delay;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.op_wr = 1'b0; bus.op_size = '0; bus.op_signed = 1'b0;
    bus.op_addr = '0; bus.op_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus64.op_valid = 1'b0; bus64.op_wr = 1'b0; bus64.op_size = '0; bus64.op_signed = 1'b0;
    bus64.op_addr = '0; bus64.op_wdata = '0; bus64.mem_ack = 1'b0; bus64.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_op_ready", bus.op_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_err", bus.rsp_err, 0);
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_mem_we", bus.mem_we, 0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_be", bus.mem_be, 0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b1;

    // Directed scenarios
    run_op(1'b0, 2'd0, 1'b1, 12'h003, 32'h0, 0, 32'h80FF_1234);   // lb signed
    run_op(1'b1, 2'd1, 1'b0, 12'h006, 32'h0000_ABCD, 0, 32'h0);   // sh
    run_op(1'b0, 2'd2, 1'b0, 12'h002, 32'h0, 0, 32'h0);           // misaligned lw
    run_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 255, 32'h0);         // timeout
    run_op(1'b0, 2'd3, 1'b0, 12'h008, 32'h0, 0, 32'h0);           // dword on 32-bit
    run_op(1'b0, 2'd1, 1'b0, 12'h00A, 32'h0, TIMEOUT - 1, 32'h8001_0000);
    run64(2'd3, 1'b0, 12'h008, 64'h8123_4567_89AB_CDEF, 8'hFF, 64'h8123_4567_89AB_CDEF);
    run64(2'd2, 1'b1, 12'h004, 64'h8000_0001_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0001);

    // Reset in the third ACCESS cycle
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_wr = 1'b0; bus.op_size = 2'd2; bus.op_addr = 12'h010;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("prerst_mem_req", bus.mem_req, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("midrst_mem_req", bus.mem_req, 0);
    check_eq("midrst_rsp_valid", bus.rsp_valid, 0);
    check_eq("midrst_op_ready", bus.op_ready, 1);
    @(negedge clk);
    check_eq("postrst_rsp_valid", bus.rsp_valid, 0);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      size = 2'($urandom_range(0, 3));
      addr = 12'($urandom);
      if ($urandom_range(0, 3) != 0) addr = addr & ~12'((1 << size) - 1);
      r = $urandom_range(0, 9);
      if (r < 7) delay = $urandom_range(0, 4);
      else if (r == 7) delay = TIMEOUT - 1;
      else delay = 255;
      run_op(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
             delay, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
